adc_sar_ctrl: RTL and testbench



---
 rtl/adc_sar_ctrl_if.sv | 16 +
 rtl/adc_sar_ctrl.sv | 145 ++++++++++++++
 tb/tb_adc_sar_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/adc_sar_ctrl_if.sv
// Request/result and DAC-side signals of the SAR ADC controller.
// The controller connects through the slave modport; the requester and the DAC/comparator side use master.
interface adc_sar_ctrl_if #(
    parameter int WIDTH = 10
);
    logic             start;
    logic             comp;
    logic             dac_en;
    logic [WIDTH-1:0] dac_d;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] data;

    modport slave  (input start, comp, output dac_en, dac_d, busy, valid, data);
    modport master (output start, comp, input dac_en, dac_d, busy, valid, data);
endinterface

// File: rtl/adc_sar_ctrl.sv
// Successive-approximation controller: DAC warm-up, MSB-first bit trials, one-cycle result strobe.
// Define ADC_SAR_OVERSAMPLE_EN to average four conversions per request.
module adc_sar_ctrl #(
    parameter int WIDTH         = 10,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    adc_sar_ctrl_if.slave sar
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MSB_CODE = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, WARM, TRIAL, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] code_q, code_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] kept;
`ifdef ADC_SAR_OVERSAMPLE_EN
    logic [1:0]       pass_q, pass_d;
    logic [WIDTH+1:0] acc_q, acc_d;
    logic [WIDTH+1:0] acc_sum;
    logic [WIDTH+1:0] rounded;

    assign acc_sum = acc_q + (WIDTH+2)'(kept);
    assign rounded = acc_sum + (WIDTH+2)'(2);
`endif

    // Trial code with the bit under test resolved by the comparator.
    assign bit_mask = MSB_CODE >> (IW'(WIDTH-1) - idx_q);
    assign kept     = sar.comp ? code_q : (code_q & ~bit_mask);

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        code_d  = code_q;
        data_d  = data_q;
`ifdef ADC_SAR_OVERSAMPLE_EN
        pass_d  = pass_q;
        acc_d   = acc_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (sar.start) begin
                    state_d = WARM;
                    cnt_d   = 4'(SETTLE_CYCLES - 1);
`ifdef ADC_SAR_OVERSAMPLE_EN
                    pass_d  = '0;
                    acc_d   = '0;
`endif
                end
            end
            WARM: begin
                if (cnt_q == 4'd0) begin
                    state_d = TRIAL;
                    cnt_d   = 4'(SETTLE_CYCLES);
                    idx_d   = IW'(WIDTH - 1);
                    code_d  = MSB_CODE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            TRIAL: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (idx_q != '0) begin
                    idx_d  = idx_q - 1'b1;
                    code_d = kept | (bit_mask >> 1);
                    cnt_d  = 4'(SETTLE_CYCLES);
                end else begin
`ifdef ADC_SAR_OVERSAMPLE_EN
                    acc_d = acc_sum;
                    if (pass_q != 2'd3) begin
                        // Next pass restarts at the MSB; the DAC is already warm.
                        pass_d = pass_q + 2'd1;
                        idx_d  = IW'(WIDTH - 1);
                        code_d = MSB_CODE;
                        cnt_d  = 4'(SETTLE_CYCLES);
                    end else begin
                        state_d = DONE;
                        code_d  = '0;
                        data_d  = rounded[WIDTH+1:2];
                    end
`else
                    state_d = DONE;
                    code_d  = '0;
                    data_d  = kept;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        en_d    = (state_d == WARM) || (state_d == TRIAL);
        busy_d  = en_d;
        valid_d = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            code_q  <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef ADC_SAR_OVERSAMPLE_EN
            pass_q  <= '0;
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            data_q  <= data_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
`ifdef ADC_SAR_OVERSAMPLE_EN
            pass_q  <= pass_d;
            acc_q   <= acc_d;
`endif
        end
    end

    assign sar.dac_en = en_q;
    assign sar.dac_d  = code_q;
    assign sar.busy   = busy_q;
    assign sar.valid  = valid_q;
    assign sar.data   = data_q;
endmodule

// File: tb/tb_adc_sar_ctrl.sv
// Directed bench for adc_sar_ctrl with an ideal comparator comp = (vin >= dac_d).
// Timing points are named by the edge that would sample the observed value.
module tb_adc_sar_ctrl;
    localparam int W     = 10;
    localparam int S     = 2;
    localparam int N     = 1 + S + W * (S + 1);
    localparam int OS_N  = 1 + S + 4 * W * (S + 1);
    localparam int MAXE  = 160;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] vin;
    int           n_checks = 0;
    int           n_fail   = 0;

    logic         en_seq    [0:MAXE];
    logic         busy_seq  [0:MAXE];
    logic         valid_seq [0:MAXE];
    logic [W-1:0] data_seq  [0:MAXE];
    logic [W-1:0] dacd_seq  [0:MAXE];

    always #5 clk = ~clk;

    adc_sar_ctrl_if #(.WIDTH(W)) sar_if ();
    assign sar_if.comp = (vin >= sar_if.dac_d);

    adc_sar_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clk   (clk),
        .reset (reset),
        .sar   (sar_if)
    );

    // Accepts a request on the next edge (edge 0) and records outputs at edges 1..n_edges.
    task automatic run_conv(input logic [W-1:0] v, input int n_edges, input bit hold, input bit extra);
        vin = v;
        for (int i = 0; i <= MAXE; i++) begin
            en_seq[i] = 1'b0; busy_seq[i] = 1'b0; valid_seq[i] = 1'b0;
            data_seq[i] = '0; dacd_seq[i] = '0;
        end
        sar_if.start = 1'b1;
        @(posedge clk); #1;
        sar_if.start = hold;
        for (int e = 1; e <= n_edges; e++) begin
            en_seq[e]    = sar_if.dac_en;
            busy_seq[e]  = sar_if.busy;
            valid_seq[e] = sar_if.valid;
            data_seq[e]  = sar_if.data;
            dacd_seq[e]  = sar_if.dac_d;
            if (extra && (e == 5 || e == 20)) sar_if.start = 1'b1;
            @(posedge clk); #1;
            sar_if.start = hold && (e < n_edges);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        sar_if.start = 1'b0;
        vin = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (sar_if.dac_en !== 1'b0) begin n_fail++; $display("FAIL reset_dac_en: got %b expected 0", sar_if.dac_en); end
        n_checks++; if (sar_if.dac_d !== '0) begin n_fail++; $display("FAIL reset_dac_d: got %h expected 000", sar_if.dac_d); end
        n_checks++; if (sar_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", sar_if.busy); end
        n_checks++; if (sar_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", sar_if.valid); end
        n_checks++; if (sar_if.data !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 000", sar_if.data); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_nominal;
        int           t_edge [5] = '{3, 6, 9, 12, 15};
        logic [W-1:0] t_code [5] = '{10'h200, 10'h300, 10'h280, 10'h2C0, 10'h2A0};
        int nval = 0;
        int first = -1;
        run_conv(10'h2A5, 36, 1'b0, 1'b0);
        n_checks++; if (en_seq[1] !== 1'b1 || busy_seq[1] !== 1'b1) begin n_fail++; $display("FAIL nominal_rise: got en=%b busy=%b expected 1 1", en_seq[1], busy_seq[1]); end
        n_checks++; if (dacd_seq[2] !== '0) begin n_fail++; $display("FAIL nominal_warm_dac_d: got %h expected 000", dacd_seq[2]); end
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (dacd_seq[t_edge[k]] !== t_code[k]) begin
                n_fail++;
                $display("FAIL nominal_trial_%0d: got %h expected %h", k, dacd_seq[t_edge[k]], t_code[k]);
            end
        end
        for (int e = 1; e <= 36; e++) if (valid_seq[e]) begin nval++; if (first < 0) first = e; end
        n_checks++; if (nval != 1 || first != N) begin n_fail++; $display("FAIL nominal_valid: got count=%0d edge=%0d expected 1 at %0d", nval, first, N); end
        n_checks++; if (data_seq[N] !== 10'h2A5) begin n_fail++; $display("FAIL nominal_data: got %h expected 2a5", data_seq[N]); end
        n_checks++; if (en_seq[N] !== 1'b0 || busy_seq[N] !== 1'b0 || dacd_seq[N] !== '0) begin n_fail++; $display("FAIL nominal_done_outputs: got en=%b busy=%b dac_d=%h expected 0 0 000", en_seq[N], busy_seq[N], dacd_seq[N]); end
        n_checks++; if (data_seq[36] !== 10'h2A5) begin n_fail++; $display("FAIL nominal_data_hold: got %h expected 2a5", data_seq[36]); end
    endtask

    task automatic test_boundaries;
        logic [W-1:0] vals [2] = '{10'h000, 10'h3FF};
        for (int k = 0; k < 2; k++) begin
            run_conv(vals[k], 36, 1'b0, 1'b0);
            n_checks++;
            if (valid_seq[N] !== 1'b1 || data_seq[N] !== vals[k]) begin
                n_fail++;
                $display("FAIL boundary_%0d_data: got valid=%b data=%h expected 1 %h", k, valid_seq[N], data_seq[N], vals[k]);
            end
            n_checks++;
            if (busy_seq[N] !== 1'b0 || en_seq[N] !== 1'b0 || busy_seq[N+1] !== 1'b0 || en_seq[N+1] !== 1'b0) begin
                n_fail++;
                $display("FAIL boundary_%0d_idle: got busy=%b%b en=%b%b expected 00 00", k, busy_seq[N], busy_seq[N+1], en_seq[N], en_seq[N+1]);
            end
        end
    endtask

    task automatic test_ignored_start;
        int nval = 0;
        int first = -1;
        run_conv(10'h2A5, 40, 1'b0, 1'b1);
        for (int e = 1; e <= 40; e++) if (valid_seq[e]) begin nval++; if (first < 0) first = e; end
        n_checks++; if (nval != 1 || first != N) begin n_fail++; $display("FAIL ignored_start_valid: got count=%0d edge=%0d expected 1 at %0d", nval, first, N); end
        n_checks++; if (data_seq[N] !== 10'h2A5) begin n_fail++; $display("FAIL ignored_start_data: got %h expected 2a5", data_seq[N]); end
    endtask

    task automatic test_back_to_back;
        int exp_edge [3] = '{33, 67, 101};
        int nval = 0;
        run_conv(10'h155, 101, 1'b1, 1'b0);
        for (int e = 1; e <= 101; e++) if (valid_seq[e]) nval++;
        n_checks++; if (nval != 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", nval); end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (valid_seq[exp_edge[k]] !== 1'b1 || data_seq[exp_edge[k]] !== 10'h155) begin
                n_fail++;
                $display("FAIL b2b_result_%0d: got valid=%b data=%h at edge %0d expected 1 155", k, valid_seq[exp_edge[k]], data_seq[exp_edge[k]], exp_edge[k]);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (sar_if.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy=%b expected 0", sar_if.busy); end
    endtask

    task automatic test_reset_mid;
        int nval = 0;
        vin = 10'h2A5;
        sar_if.start = 1'b1;
        @(posedge clk); #1;
        sar_if.start = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        n_checks++; if (sar_if.dac_en !== 1'b1 || sar_if.busy !== 1'b1) begin n_fail++; $display("FAIL midreset_pre: got en=%b busy=%b expected 1 1", sar_if.dac_en, sar_if.busy); end
        reset = 1'b1;
        #1;
        n_checks++; if (sar_if.dac_en !== 1'b0 || sar_if.busy !== 1'b0 || sar_if.dac_d !== '0) begin n_fail++; $display("FAIL midreset_abort: got en=%b busy=%b dac_d=%h expected 0 0 000", sar_if.dac_en, sar_if.busy, sar_if.dac_d); end
        n_checks++; if (sar_if.data !== '0 || sar_if.valid !== 1'b0) begin n_fail++; $display("FAIL midreset_data: got data=%h valid=%b expected 000 0", sar_if.data, sar_if.valid); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int e = 0; e < 36; e++) begin
            @(posedge clk); #1;
            if (sar_if.valid) nval++;
        end
        n_checks++; if (nval != 0 || sar_if.data !== '0) begin n_fail++; $display("FAIL midreset_no_valid: got count=%0d data=%h expected 0 000", nval, sar_if.data); end
        run_conv(10'h0F3, 36, 1'b0, 1'b0);
        n_checks++; if (valid_seq[N] !== 1'b1 || data_seq[N] !== 10'h0F3) begin n_fail++; $display("FAIL midreset_reconvert: got valid=%b data=%h expected 1 0f3", valid_seq[N], data_seq[N]); end
    endtask

`ifdef ADC_SAR_OVERSAMPLE_EN
    task automatic test_oversample;
        logic [W-1:0] vtab [4] = '{10'h100, 10'h101, 10'h101, 10'h102};
        logic [W-1:0] prev_d = '0;
        logic [W-1:0] vdata  = '0;
        int  seen  = 0;
        int  vedge = -1;
        bit  en_ok = 1'b1;
        logic en_after = 1'b1;
        vin = vtab[0];
        sar_if.start = 1'b1;
        @(posedge clk); #1;
        sar_if.start = 1'b0;
        for (int e = 1; e <= OS_N + 4; e++) begin
            if (sar_if.dac_d == 10'h200 && prev_d != 10'h200) begin
                if (seen < 4) vin = vtab[seen];
                seen++;
            end
            if (e < OS_N && !sar_if.dac_en) en_ok = 1'b0;
            if (e == OS_N) en_after = sar_if.dac_en;
            if (sar_if.valid && vedge < 0) begin vedge = e; vdata = sar_if.data; end
            prev_d = sar_if.dac_d;
            @(posedge clk); #1;
        end
        n_checks++; if (seen != 4) begin n_fail++; $display("FAIL os_passes: got %0d expected 4", seen); end
        n_checks++; if (vedge != OS_N) begin n_fail++; $display("FAIL os_valid_edge: got %0d expected %0d", vedge, OS_N); end
        n_checks++; if (vdata !== 10'h101) begin n_fail++; $display("FAIL os_data: got %h expected 101", vdata); end
        n_checks++; if (!en_ok || en_after !== 1'b0) begin n_fail++; $display("FAIL os_dac_en: got continuous=%0d final=%b expected 1 0", en_ok, en_after); end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_boundaries();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
`ifdef ADC_SAR_OVERSAMPLE_EN
        test_oversample();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
